// File: rtl/cond_flag_unit_if.sv
// Bus bundle for cond_flag_unit.
// The master side drives the ALU result, control and condition code; the slave side returns flags and stack status.
interface cond_flag_unit_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             aluResult;
  logic [WIDTH-1:0]             aluCarry;
  logic                         is32;
  logic                         setFlag;
  logic                         push;
  logic                         pop;
  logic [3:0]                   cond;
  logic                         zFlag;
  logic                         oFlag;
  logic                         cFlag;
  logic                         nFlag;
  logic                         condPass;
  logic [$clog2(DEPTH+1)-1:0]   depthCount;
  logic                         stackFull;
  logic                         stackEmpty;
  logic                         stackErr;

  modport master (
    output aluResult, aluCarry, is32, setFlag, push, pop, cond,
    input  zFlag, oFlag, cFlag, nFlag, condPass, depthCount,
           stackFull, stackEmpty, stackErr
  );

  modport slave (
    input  aluResult, aluCarry, is32, setFlag, push, pop, cond,
    output zFlag, oFlag, cFlag, nFlag, condPass, depthCount,
           stackFull, stackEmpty, stackErr
  );
endinterface

// File: rtl/cond_flag_unit.sv
// NZCV flag derivation, flag register, ARM condition evaluator and flag save/restore stack.
// Optional macro FLAG_BYPASS_EN forwards freshly derived flags into condPass while setFlag is asserted.
module cond_flag_unit #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  cond_flag_unit_if.slave  bus
);
  localparam int DW     = $clog2(DEPTH + 1);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MSB_W  = WIDTH - 1;
  localparam int MSB_32 = (WIDTH > 32) ? 31 : WIDTH - 1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  flags_t          flags_q, flags_d;
  flags_t          derived, evalFlags, topEntry;
  flags_t          stack_q [DEPTH];
  logic [DW-1:0]   depth_q, depth_d;
  logic            err_q, err_d;
  logic            full, empty;
  logic            doPush, doPop, doSwap, pushErr, popErr;
  logic [AW-1:0]   wrIdx, topIdx;

  // W-register mode only narrows the view when the datapath is wider than 32 bits.
  always_comb begin
    derived = '0;
    if (bus.is32 && (WIDTH > 32)) begin
      derived.n = bus.aluResult[MSB_32];
      derived.z = ~|bus.aluResult[MSB_32:0];
      derived.c = bus.aluCarry[MSB_32];
      derived.v = bus.aluCarry[MSB_32] ^ bus.aluCarry[MSB_32-1];
    end else begin
      derived.n = bus.aluResult[MSB_W];
      derived.z = ~|bus.aluResult;
      derived.c = bus.aluCarry[MSB_W];
      derived.v = bus.aluCarry[MSB_W] ^ bus.aluCarry[MSB_W-1];
    end
  end

  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);
  // Push+pop on an empty stack degrades to a plain push plus an error.
  assign doSwap   = bus.push & bus.pop & ~empty;
  assign doPush   = bus.push & ~full & (~bus.pop | empty);
  assign doPop    = bus.pop & ~bus.push & ~empty;
  assign pushErr  = bus.push & ~bus.pop & full;
  assign popErr   = bus.pop & empty;
  assign wrIdx    = AW'(depth_q);
  assign topIdx   = AW'(depth_q - 1'b1);
  assign topEntry = stack_q[topIdx];

  always_comb begin
    flags_d = flags_q;
    depth_d = depth_q;
    err_d   = err_q | pushErr | popErr;
    if (doPop || doSwap) begin
      flags_d = topEntry;
    end else if (bus.setFlag) begin
      flags_d = derived;
    end
    if (doPush) begin
      depth_d = depth_q + 1'b1;
    end else if (doPop) begin
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage has no reset; entries above depthCount are never read.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (doPush) begin
        stack_q[wrIdx] <= flags_q;
      end else if (doSwap) begin
        stack_q[topIdx] <= flags_q;
      end
    end
  end

`ifdef FLAG_BYPASS_EN
  assign evalFlags = (bus.setFlag && !bus.pop) ? derived : flags_q;
`else
  assign evalFlags = flags_q;
`endif

  always_comb begin
    bus.condPass = 1'b1;
    unique case (bus.cond)
      4'd0:    bus.condPass = evalFlags.z;
      4'd1:    bus.condPass = ~evalFlags.z;
      4'd2:    bus.condPass = evalFlags.c;
      4'd3:    bus.condPass = ~evalFlags.c;
      4'd4:    bus.condPass = evalFlags.n;
      4'd5:    bus.condPass = ~evalFlags.n;
      4'd6:    bus.condPass = evalFlags.v;
      4'd7:    bus.condPass = ~evalFlags.v;
      4'd8:    bus.condPass = evalFlags.c & ~evalFlags.z;
      4'd9:    bus.condPass = ~evalFlags.c | evalFlags.z;
      4'd10:   bus.condPass = (evalFlags.n == evalFlags.v);
      4'd11:   bus.condPass = (evalFlags.n != evalFlags.v);
      4'd12:   bus.condPass = ~evalFlags.z & (evalFlags.n == evalFlags.v);
      4'd13:   bus.condPass = evalFlags.z | (evalFlags.n != evalFlags.v);
      default: bus.condPass = 1'b1;
    endcase
  end

  assign bus.nFlag      = flags_q.n;
  assign bus.zFlag      = flags_q.z;
  assign bus.cFlag      = flags_q.c;
  assign bus.oFlag      = flags_q.v;
  assign bus.depthCount = depth_q;
  assign bus.stackFull  = full;
  assign bus.stackEmpty = empty;
  assign bus.stackErr   = err_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed testbench for cond_flag_unit: a queue-based reference model feeds a scoreboard
// of expected register/stack state, plus fixed expectations taken from the flag and condition tables.
module tb_cond_flag_unit;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  localparam logic [63:0] R0 = 64'h0;
  localparam logic [63:0] RN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] R1 = 64'h1;
  localparam logic [63:0] RH = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] C1 = '1;
  localparam logic [63:0] C0 = 64'h0;
  localparam logic [63:0] CV = 64'h4000_0000_0000_0000;
  localparam logic [63:0] CC = 64'h8000_0000_0000_0000;

  // NZCV patterns produced by the input pairs above
  localparam logic [3:0] P1 = 4'b0110;
  localparam logic [3:0] P2 = 4'b1001;
  localparam logic [3:0] P3 = 4'b0100;
  localparam logic [3:0] P4 = 4'b0011;

  typedef struct {
    string      tag;
    logic [3:0] flags;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount = 0;

  exp_t       sbQ[$];
  logic [3:0] mStack[$];
  logic [3:0] mFlags;
  logic       mErr;

  cond_flag_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  cond_flag_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] deriveModel(input logic i32, input logic [63:0] r,
                                             input logic [63:0] c);
    int   top;
    logic n, z, cf, v;
    top = i32 ? 31 : 63;
    n   = r[top];
    z   = i32 ? (r[31:0] == 32'd0) : (r == 64'd0);
    cf  = c[top];
    v   = c[top] ^ c[top-1];
    return {n, z, cf, v};
  endfunction

  function automatic logic condModel(input logic [3:0] f, input logic [3:0] cc);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return c;
      4'd3:    return !c;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return c && !z;
      4'd9:    return !c || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dutFlags();
    return {bus.nFlag, bus.zFlag, bus.cFlag, bus.oFlag};
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      checkEq("scoreboard_empty", 16'd1, 16'd0);
      return;
    end
    e = sbQ.pop_front();
    checkEq({e.tag, "_flags"}, {12'd0, dutFlags()}, {12'd0, e.flags});
    checkEq({e.tag, "_depth"}, {13'd0, bus.depthCount}, {13'd0, e.depth});
    checkEq({e.tag, "_full"}, {15'd0, bus.stackFull}, {15'd0, e.full});
    checkEq({e.tag, "_empty"}, {15'd0, bus.stackEmpty}, {15'd0, e.empty});
    checkEq({e.tag, "_err"}, {15'd0, bus.stackErr}, {15'd0, e.err});
  endtask

  // Drive one cycle of stimulus, advance the model, queue its prediction, then check after the edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic sf,
                               input logic ps, input logic pp, input logic i32,
                               input logic [63:0] res, input logic [63:0] car);
    logic [3:0] old, nf;
    exp_t       e;
    reset       = rst;
    bus.setFlag = sf;
    bus.push    = ps;
    bus.pop     = pp;
    bus.is32    = i32;
    bus.aluResult = res;
    bus.aluCarry  = car;
    if (!rst) begin
      mFlags = 4'b0000;
      mStack.delete();
      mErr = 1'b0;
    end else begin
      old = mFlags;
      nf  = sf ? deriveModel(i32, res, car) : old;
      if (ps && pp) begin
        if (mStack.size() > 0) begin
          nf = mStack[mStack.size()-1];
          mStack[mStack.size()-1] = old;
        end else begin
          mStack.push_back(old);
          mErr = 1'b1;
        end
      end else if (ps) begin
        if (mStack.size() < DEPTH) mStack.push_back(old);
        else mErr = 1'b1;
      end else if (pp) begin
        if (mStack.size() > 0) nf = mStack.pop_back();
        else mErr = 1'b1;
      end
      mFlags = nf;
    end
    e.tag   = tag;
    e.flags = mFlags;
    e.depth = 3'(mStack.size());
    e.full  = (mStack.size() == DEPTH);
    e.empty = (mStack.size() == 0);
    e.err   = mErr;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [15:0] condVec;
    bus.cond = 4'd14;
    mFlags = 4'b0000;
    mErr = 1'b0;

    $display("[TB] reset phase");
    applyStimulus("rst0", 0, 1, 0, 0, 0, R0, C1);
    applyStimulus("rst1", 0, 1, 0, 0, 0, R0, C1);
    checkEq("rst_flags", {12'd0, dutFlags()}, 16'h0000);
    checkEq("rst_empty", {15'd0, bus.stackEmpty}, 16'd1);

    $display("[TB] 64-bit derivation");
    applyStimulus("d64_zero", 1, 1, 0, 0, 0, R0, C1);
    checkEq("d64_zero_nzcv", {12'd0, dutFlags()}, {12'd0, P1});
    applyStimulus("d64_neg", 1, 1, 0, 0, 0, RN, CV);
    checkEq("d64_neg_nzcv", {12'd0, dutFlags()}, {12'd0, P2});
    for (int i = 0; i < 3; i++) applyStimulus("hold", 1, 0, 0, 0, 0, R0, C1);
    checkEq("hold_nzcv", {12'd0, dutFlags()}, {12'd0, P2});

    $display("[TB] is32 mode");
    applyStimulus("w32", 1, 1, 0, 0, 1, RH, C0);
    checkEq("w32_nzcv", {12'd0, dutFlags()}, 16'h0004);
    applyStimulus("x64", 1, 1, 0, 0, 0, RH, C0);
    checkEq("x64_nzcv", {12'd0, dutFlags()}, 16'h0008);

    $display("[TB] stack fill and drain");
    applyStimulus("ld_p1", 1, 1, 0, 0, 0, R0, C1);
    applyStimulus("push_p1", 1, 1, 1, 0, 0, RN, CV);
    applyStimulus("push_p2", 1, 1, 1, 0, 0, R0, C0);
    applyStimulus("push_p3", 1, 1, 1, 0, 0, R1, CC);
    applyStimulus("push_p4", 1, 0, 1, 0, 0, R0, C0);
    checkEq("full_after4", {15'd0, bus.stackFull}, 16'd1);
    applyStimulus("push_full", 1, 0, 1, 0, 0, R0, C0);
    checkEq("push_full_err", {15'd0, bus.stackErr}, 16'd1);
    checkEq("push_full_depth", {13'd0, bus.depthCount}, 16'd4);
    applyStimulus("pop1", 1, 0, 0, 1, 0, R0, C0);
    checkEq("pop1_nzcv", {12'd0, dutFlags()}, {12'd0, P4});
    applyStimulus("pop2", 1, 0, 0, 1, 0, R0, C0);
    checkEq("pop2_nzcv", {12'd0, dutFlags()}, {12'd0, P3});
    applyStimulus("pop3", 1, 0, 0, 1, 0, R0, C0);
    checkEq("pop3_nzcv", {12'd0, dutFlags()}, {12'd0, P2});
    applyStimulus("pop4", 1, 0, 0, 1, 0, R0, C0);
    checkEq("pop4_nzcv", {12'd0, dutFlags()}, {12'd0, P1});
    applyStimulus("pop_empty", 1, 0, 0, 1, 0, R0, C0);
    checkEq("pop_empty_nzcv", {12'd0, dutFlags()}, {12'd0, P1});
    checkEq("pop_empty_depth", {13'd0, bus.depthCount}, 16'd0);

    $display("[TB] swap and pop priority");
    applyStimulus("sw_ld", 1, 1, 0, 0, 0, R0, C1);
    applyStimulus("sw_push1", 1, 1, 1, 0, 0, RN, CV);
    applyStimulus("sw_push2", 1, 1, 1, 0, 0, R0, C0);
    applyStimulus("swap", 1, 0, 1, 1, 0, R0, C0);
    checkEq("swap_nzcv", {12'd0, dutFlags()}, {12'd0, P2});
    checkEq("swap_depth", {13'd0, bus.depthCount}, 16'd2);
    applyStimulus("swap_pop", 1, 0, 0, 1, 0, R0, C0);
    checkEq("swap_top_nzcv", {12'd0, dutFlags()}, {12'd0, P3});
    applyStimulus("pop_set", 1, 1, 0, 1, 0, R1, CC);
    checkEq("pop_set_nzcv", {12'd0, dutFlags()}, {12'd0, P1});
    applyStimulus("popempty_set", 1, 1, 0, 1, 0, R1, CC);
    checkEq("popempty_set_nzcv", {12'd0, dutFlags()}, {12'd0, P4});
    applyStimulus("rst2", 0, 0, 0, 0, 0, R0, C0);
    applyStimulus("pp_empty", 1, 0, 1, 1, 0, R0, C0);
    checkEq("pp_empty_err", {15'd0, bus.stackErr}, 16'd1);
    checkEq("pp_empty_depth", {13'd0, bus.depthCount}, 16'd1);

    $display("[TB] condition sweep");
    applyStimulus("ld_n", 1, 1, 0, 0, 0, RN, C0);
    condVec = '0;
    for (int cc = 0; cc < 16; cc++) begin
      bus.cond = 4'(cc);
      #1;
      condVec[cc] = bus.condPass;
      checkEq($sformatf("cond_%0d", cc), {15'd0, bus.condPass}, {15'd0, condModel(mFlags, 4'(cc))});
    end
    checkEq("cond_table", condVec, 16'hEA9A);

    $display("[TB] condition source timing");
    bus.cond      = 4'd0;
    bus.setFlag   = 1'b1;
    bus.aluResult = R0;
    bus.aluCarry  = C1;
    #1;
`ifdef FLAG_BYPASS_EN
    checkEq("eq_same_cycle", {15'd0, bus.condPass}, 16'd1);
`else
    checkEq("eq_same_cycle", {15'd0, bus.condPass}, 16'd0);
`endif
    applyStimulus("byp_reg", 1, 1, 0, 0, 0, R0, C1);
    bus.setFlag = 1'b0;
    #1;
    checkEq("eq_next_cycle", {15'd0, bus.condPass}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Parametrised NZCV condition-flag unit for the pipelined ARM datapath, sitting between the ALU bitSlice array and the branch/conditional-select logic. It derives zero, overflow, carry and negative from the ALU result and per-bit carry chain in 64-bit or 32-bit (W-register) mode. It holds the flags in a write-enabled register and evaluates a 4-bit ARM condition code against them. It also provides a DEPTH-entry save/restore stack for nested exception and call contexts.

## Interface
Parameters:
- WIDTH, 64, datapath width; must be ≥ 2
- DEPTH, 4, flag-stack entries; must be ≥ 1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- aluResult  input  WIDTH  ALU result bits
- aluCarry  input  WIDTH  per-bit carry-out of each bitSlice
- is32  input  1  derive flags from bit 31 instead of bit WIDTH-1; ignored when WIDTH ≤ 32
- setFlag  input  1  load derived flags at next edge
- push  input  1  save the current registered flags onto the stack
- pop  input  1  restore the flag register from the top of the stack
- cond  input  4  ARM condition code to evaluate
- zFlag, oFlag, cFlag, nFlag  output  1 each  registered flags
- condPass  output  1  cond satisfied (combinational)
- depthCount  output  $clog2(DEPTH+1)  occupied stack entries
- stackFull, stackEmpty  output  1 each  depthCount==DEPTH / ==0
- stackErr  output  1  sticky push-when-full or pop-when-empty

## Operation
- Derivation uses msb = (is32 && WIDTH>32) ? 31 : WIDTH-1.
  - N = aluResult[msb]
  - Z = ~|aluResult[msb:0]
  - C = aluCarry[msb]
  - V = aluCarry[msb] ^ aluCarry[msb-1]
- Flag register priority at each edge: pop (when not empty) > setFlag > hold.
- push when not full: writes the pre-edge registered flags to stack[depthCount] and increments depthCount.
- pop when not empty: loads stack[depthCount-1] into the flag register and decrements depthCount.
- push and pop in the same cycle:
  - Flag register takes the popped top entry.
  - The top entry is overwritten with the pre-edge flags, so the register and top entry swap.
  - depthCount is unchanged.
  - Legal even when full. When empty, this is treated as push only and stackErr is set.
- Error cases:
  - push when full: no stack change; stackErr set.
  - pop when empty: no flag change; stackErr set.
  - A setFlag in the same cycle as a failed pop still applies.
- stackErr clears only on reset.
- Condition codes:
  - 0 EQ Z; 1 NE !Z
  - 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 1
- Stack contents are not cleared by reset. Only depthCount resets.

## Timing
- Reset (reset==0 at an edge): all four flags 0, depthCount 0, stackEmpty 1, stackFull 0, stackErr 0.
  - Reset overrides setFlag, push and pop in the same cycle.
- Flag update latency: 1 cycle. Values sampled at edge k are visible on the outputs after edge k.
- stackFull, stackEmpty and depthCount update at the same edge as the push or pop.
- condPass is combinational from cond and the flag source. It has no register stage.

## Configuration
- FLAG_BYPASS_EN
  - Defined: when setFlag==1 and pop==0, condPass evaluates against the freshly derived flags of the current cycle. This gives a same-cycle CMP→B.cond forward.
  - Defined, otherwise: condPass uses the registered flags.
  - Not defined: condPass always uses the registered flags, one cycle after setFlag.
- Register, stack and error behaviour is identical in both builds.

## Test plan
- Reset: hold reset=0 for 2 cycles with setFlag=1 and aluResult=0 → all flags 0, stackEmpty=1, stackErr=0.
- 64-bit derivation:
  - aluResult=0, aluCarry='1, setFlag=1 → Z=1, C=1, V=0, N=0.
  - aluResult=64'h8000_0000_0000_0000, aluCarry=64'h4000_0000_0000_0000 → N=1, Z=0, C=0, V=1.
  - setFlag=0 for 3 cycles → flags hold.
- is32 mode: aluResult=64'hFFFF_FFFF_0000_0000, is32=1, setFlag=1 → Z=1, N=0. Same input with is32=0 → Z=0, N=1.
- Stack (DEPTH=4):
  - 4 pushes of distinct flag patterns → stackFull=1.
  - 5th push → stackErr=1, depthCount=4.
  - 4 pops restore the patterns in LIFO order.
  - Extra pop → flags unchanged, depthCount=0.
- Simultaneous push+pop at depth 2 → register and top entry swap, depthCount stays 2. Pop+setFlag together → popped value wins.
- Conditions:
  - Flags N=1, V=0, Z=0: sweep cond 0–15 → GE=0, LT=1, GT=0, LE=1, AL=NV=1.
  - With FLAG_BYPASS_EN defined: condPass reflects the setFlag inputs in the same cycle.
  - Without FLAG_BYPASS_EN: condPass reflects them one cycle later.
